// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit
// per clock, with a start/busy/done handshake and registered sum/carry-out.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  // Single-bit full adder cell on the operand LSBs and the running carry
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the completed word straight from the shifter input
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed cases plus WIDTH=3 exhaustive,
// checked every cycle against a transaction-timeline model and by literal expectations.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted request is busy for WIDTH+1 cycles after the accepting
  // edge, done in the last of them, and the result {cout,sum} is simply a+b+cin.
  logic       m8_act, m3_act;
  int         m8_k, m3_k;
  logic [8:0] m8_res, m8_exp;
  logic [3:0] m3_res, m3_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_act <= 1'b0; m8_k <= 0; m8_res <= '0; m8_exp <= '0;
    end else if (!m8_act) begin
      if (start8) begin
        m8_act <= 1'b1; m8_k <= 0;
        m8_exp <= 9'(a8) + 9'(b8) + 9'(cin8);
      end
    end else begin
      m8_k <= m8_k + 1;
      if (m8_k + 1 == 8) m8_res <= m8_exp;
      if (m8_k + 1 > 8) m8_act <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_act <= 1'b0; m3_k <= 0; m3_res <= '0; m3_exp <= '0;
    end else if (!m3_act) begin
      if (start3) begin
        m3_act <= 1'b1; m3_k <= 0;
        m3_exp <= 4'(a3) + 4'(b3) + 4'(cin3);
      end
    end else begin
      m3_k <= m3_k + 1;
      if (m3_k + 1 == 3) m3_res <= m3_exp;
      if (m3_k + 1 > 3) m3_act <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy8", 32'(busy8), 32'(m8_act));
      check("done8", 32'(done8), 32'(m8_act && m8_k == 8));
      check("sum8",  32'(sum8),  32'(m8_res[7:0]));
      check("cout8", 32'(cout8), 32'(m8_res[8]));
      check("busy3", 32'(busy3), 32'(m3_act));
      check("done3", 32'(done3), 32'(m3_act && m3_k == 3));
      check("sum3",  32'(sum3),  32'(m3_res[2:0]));
      check("cout3", 32'(cout3), 32'(m3_res[3]));
    end
  end

  // Called just after a negedge; returns just after the negedge where busy has fallen.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input string nm);
    int  n = 0;
    bit  got = 1'b0;
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
        check({nm, "_busy_rise"}, 32'(busy8), 32'd1);
      end
      if (got && i == n + 1) begin
        check({nm, "_busy_fall"}, 32'(busy8), 32'd0);
        break;
      end
      if (done8 && !got) begin
        got = 1'b1; n = i;
        check({nm, "_sum"}, 32'(sum8), 32'(es));
        check({nm, "_cout"}, 32'(cout8), 32'(ec));
      end
    end
    check({nm, "_latency"}, 32'(n), 32'd9);
  endtask

  task automatic run3(input logic [2:0] ta, input logic [2:0] tb, input logic tc);
    int n = 0;
    int e;
    e = int'(ta) + int'(tb) + int'(tc);
    start3 = 1'b1; a3 = ta; b3 = tb; cin3 = tc;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start3 = 1'b0; a3 = ~ta; b3 = ~tb;
      end
      if (n != 0 && i == n + 1) break;
      if (done3 && n == 0) begin
        n = i;
        check("w3_sum", 32'(sum3), 32'(e[2:0]));
        check("w3_cout", 32'(cout3), 32'(e[3]));
      end
    end
    check("w3_latency", 32'(n), 32'd4);
  endtask

  initial begin
    int d1, d2, nd;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_sum3",  32'(sum3),  32'd0);
    rst_n = 1'b1;

    run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "basic");
    check("model_pin_basic", 32'(m8_res), 32'h08D);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_p1");
    run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ff_cin");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_cin");
    check("model_pin_max", 32'(m8_res), 32'h1FF);
    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");

    // Back-to-back with start held high
    d1 = 0; d2 = 0; nd = 0;
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin a8 = 8'h80; b8 = 8'h80; end
      if (i == 11) start8 = 1'b0;
      if (i == 14) check("b2b_hold_sum", 32'(sum8), 32'h10);
      if (done8) begin
        nd++;
        if (nd == 1) begin
          d1 = i;
          check("b2b_sum1", 32'(sum8), 32'h10);
          check("b2b_cout1", 32'(cout8), 32'd0);
        end else if (nd == 2) begin
          d2 = i;
          check("b2b_sum2", 32'(sum8), 32'h00);
          check("b2b_cout2", 32'(cout8), 32'd1);
        end
      end
    end
    check("b2b_count", 32'(nd), 32'd2);
    check("b2b_spacing", 32'(d2 - d1), 32'd10);

    // Start and operand changes while busy are ignored
    nd = 0;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (i == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
      if (i == 4) begin start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; end
      if (done8) begin
        nd++;
        check("ign_sum", 32'(sum8), 32'h30);
        check("ign_cout", 32'(cout8), 32'd0);
      end
    end
    check("ign_count", 32'(nd), 32'd1);

    // Asynchronous reset four edges into an operation
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_sum",  32'(sum8),  32'd0);
    check("mid_rst_cout", 32'(cout8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    check("mid_rst_no_done", 32'(nd), 32'd0);
    run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_rst");

    for (int v = 0; v < 128; v++) begin
      logic [6:0] vv;
      vv = 7'(v);
      run3(vv[6:4], vv[3:1], vv[0]);
    end
    check("model_pin_w3", 32'(m3_res), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
